match_collect: RTL

MATCH_COLLECT -- requirements
Module: match_collect

---
 rtl/match_collect_pkg.sv | 15 +
 rtl/match_collect_prio_enc.sv | 24 ++
 rtl/match_collect.sv | 122 ++++++++++++
 3 files changed

// File: rtl/match_collect_pkg.sv
// Shared constants and types for the match-result collector.
package match_collect_pkg;

  localparam int unsigned W_C_LENGTH  = 64;
  localparam int unsigned IA          = 4;
  localparam int unsigned N_WORDS_DEF = W_C_LENGTH;
  localparam int unsigned POS_W_DEF   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/match_collect_prio_enc.sv
// Lowest-set-bit priority encoder; combinational index and found flag.
module prio_enc #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]                                req_i,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]    idx_c_o,
  output logic                                            found_c_o
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_c_o   = '0;
    found_c_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_c_o   = IDX_W'(i);
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_collect.sv
// Serialises a snapshot of per-word match hits into an index/position stream,
// lowest index first, with ready/valid flow control and a frame-done pulse.
module match_collect
  import match_collect_pkg::*;
#(
  parameter int unsigned N_WORDS = N_WORDS_DEF,
  parameter int unsigned POS_W   = POS_W_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_valid [0:N_WORDS-1],
  input  logic [POS_W-1:0]             i_pos   [0:N_WORDS-1],
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(N_WORDS)-1:0]   o_idx,
  output logic [POS_W-1:0]             o_pos,
  output logic                         o_last,
  output logic                         o_done,
  output logic                         o_busy,
  output logic [$clog2(N_WORDS):0]     o_hit_count
);

  localparam int unsigned IDX_W = $clog2(N_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;

  state_e             state_q, state_d;
  logic [N_WORDS-1:0] mask_q, mask_d;
  logic [POS_W-1:0]   snap_q [N_WORDS];
  logic [POS_W-1:0]   snap_d [N_WORDS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_found;
  logic               xfer;

  // Outputs are computed from the next-state mask so they register with it.
  prio_enc #(.WIDTH(N_WORDS)) u_prio_enc (
    .req_i     (mask_d),
    .idx_c_o   (enc_idx),
    .found_c_o (enc_found)
  );

  assign xfer = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          for (int i = 0; i < N_WORDS; i++) begin
            mask_d[i] = i_valid[i];
            snap_d[i] = i_pos[i];
          end
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (xfer) begin
          mask_d[idx_q] = 1'b0;
          cnt_d         = cnt_q + CNT_W'(1);
        end
        if (mask_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SCAN) && enc_found;
    idx_d   = valid_d ? enc_idx : '0;
    pos_d   = valid_d ? snap_d[enc_idx] : '0;
    last_d  = valid_d && ((mask_d & (mask_d - N_WORDS'(1))) == '0);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      snap_q  <= '{default: '0};
      cnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_idx       = idx_q;
  assign o_pos       = pos_q;
  assign o_last      = last_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;
  assign o_hit_count = cnt_q;

endmodule
